fractal_stream_buffer: RTL and testbench

Elastic buffer between the colorizer output and the external AXI4-Stream video master port. The colorizer produces pixels at a fixed rate and cannot be stalled, so this block absorbs `m_axis_tready` backpressure in a FIFO. On overflow it discards the rest of the current frame and resynchronises on the next start-of-frame beat, so downstream never sees a frame spliced onto another. It also reports overflow episodes and the fill level for the register block.

---
 rtl/fractal_stream_pkg.sv | 21 ++
 rtl/fractal_sync_fifo.sv | 63 ++++++
 rtl/fractal_stream_buffer.sv | 129 ++++++++++++
 tb/tb_fractal_stream_buffer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fractal_stream_pkg.sv
// Purpose: shared types and sizing helpers for the fractal video stream buffer.
// Latency: n/a (package only).
// Backpressure: n/a.
package fractal_stream_pkg;

  // Ingest state: hunting for a frame start, forwarding, or discarding after an overflow.
  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } stream_state_t;

  // Overflow episode counter width.
  localparam int OVF_CNT_W = 16;

  // Stored entry is {frame_start, line_end, data}.
  function automatic int entry_width(input int data_width);
    return data_width + 2;
  endfunction

endpackage

// File: rtl/fractal_sync_fifo.sv
// Purpose: single-clock FIFO with registered (synchronous) read data and a fill level.
// Latency: write visible in o_level/o_empty next cycle; o_rd_dat valid the cycle after i_rd_en.
// Backpressure: none internally; writes when full and reads when empty are ignored.
// Ports: clk/rst (sync, active-high); i_wr_en/i_wr_dat push; i_rd_en pops into o_rd_dat;
//        o_full/o_empty flags and o_level (entries in storage) reflect start-of-cycle state.
module fractal_sync_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_wr_en,
  input  logic [WIDTH-1:0]           i_wr_dat,
  input  logic                       i_rd_en,
  output logic [WIDTH-1:0]           o_rd_dat,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_rd_dat;
  logic             w_wr;
  logic             w_rd;

  // Pointers carry one extra MSB so equal low bits can mean either full or empty.
  assign o_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty  = (r_wr_ptr == r_rd_ptr);
  assign o_level  = r_wr_ptr - r_rd_ptr;
  assign o_rd_dat = r_rd_dat;

  assign w_wr = i_wr_en && !o_full;
  assign w_rd = i_rd_en && !o_empty;

  // Storage carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wr_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_rd_dat <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_rd) begin
        r_rd_dat <= r_mem[r_rd_ptr[AW-1:0]];
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/fractal_stream_buffer.sv
// Purpose: elastic buffer from the non-stallable colorizer to an AXI4-Stream master port.
// Latency: 2 cycles from input beat to m_axis_tvalid with an empty FIFO; 1 beat/cycle sustained.
// Backpressure: m_axis_tready stalls are absorbed in the FIFO; on overflow the rest of the
//               frame is discarded and the stream resyncs on the next frame start.
// Ports: aclk/areset (sync, active-high); s_* colorizer beat (no ready); m_axis_* AXIS master;
//        clr_status clears overflow_sticky/overflow_count; level = entries in FIFO storage.
module fractal_stream_buffer
  import fractal_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH      = 1024
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [DATA_WIDTH-1:0]     s_data,
  input  logic                      s_frame_start,
  input  logic                      s_line_end,
  input  logic                      s_valid,
  output logic                      m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]   m_axis_tstrb,
  output logic                      m_axis_tuser,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready,
  input  logic                      clr_status,
  output logic                      overflow_sticky,
  output logic [OVF_CNT_W-1:0]      overflow_count,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int EW = entry_width(DATA_WIDTH);
  localparam logic [OVF_CNT_W-1:0] CNT_ONE = {{(OVF_CNT_W-1){1'b0}}, 1'b1};

  stream_state_t          r_state;
  logic                   r_tvalid;
  logic                   r_sticky;
  logic [OVF_CNT_W-1:0]   r_cnt;

  logic                   w_wr_en;
  logic                   w_ovf;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic [EW-1:0]          w_wr_dat;
  logic [EW-1:0]          w_rd_dat;
  logic [$clog2(DEPTH):0] w_level;

  assign w_wr_dat = {s_frame_start, s_line_end, s_data};

  // Write/overflow decode. w_full is the start-of-cycle flag, so a pop this cycle
  // never frees a slot for this cycle's write.
  always_comb begin
    w_wr_en = 1'b0;
    w_ovf   = 1'b0;
    case (r_state)
      ST_SYNC: w_wr_en = s_valid && s_frame_start && !w_full;
      ST_PASS: begin
        w_wr_en = s_valid && !w_full;
        w_ovf   = s_valid && w_full;
      end
      ST_DROP: w_wr_en = s_valid && s_frame_start && !w_full;
      default: w_wr_en = 1'b0;
    endcase
  end

  // The FIFO's registered read data is the output data register; r_tvalid qualifies it.
  // Reload whenever the register is empty or is being accepted this cycle.
  assign w_pop = !w_empty && (!r_tvalid || m_axis_tready);

  fractal_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (aclk),
    .rst      (areset),
    .i_wr_en  (w_wr_en),
    .i_wr_dat (w_wr_dat),
    .i_rd_en  (w_pop),
    .o_rd_dat (w_rd_dat),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_level  (w_level)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state  <= ST_SYNC;
      r_tvalid <= 1'b0;
      r_sticky <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        ST_SYNC: if (s_valid && s_frame_start) r_state <= ST_PASS;
        ST_PASS: if (w_ovf)                    r_state <= ST_DROP;
        ST_DROP: if (w_wr_en)                  r_state <= ST_PASS;
        default:                               r_state <= ST_SYNC;
      endcase

      if (w_pop) begin
        r_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        r_tvalid <= 1'b0;
      end

      // A new episode beats a simultaneous clear: the clear applies first, then the count.
      if (w_ovf) begin
        r_sticky <= 1'b1;
        if (clr_status) begin
          r_cnt <= CNT_ONE;
        end else if (r_cnt != {OVF_CNT_W{1'b1}}) begin
          r_cnt <= r_cnt + CNT_ONE;
        end
      end else if (clr_status) begin
        r_sticky <= 1'b0;
        r_cnt    <= '0;
      end
    end
  end

  assign m_axis_tvalid   = r_tvalid;
  assign m_axis_tuser    = w_rd_dat[EW-1];
  assign m_axis_tlast    = w_rd_dat[EW-2];
  assign m_axis_tdata    = w_rd_dat[DATA_WIDTH-1:0];
  assign m_axis_tstrb    = '1;
  assign overflow_sticky = r_sticky;
  assign overflow_count  = r_cnt;
  assign level           = w_level;

endmodule

// File: tb/tb_fractal_stream_buffer.sv
// Purpose: directed self-checking bench for fractal_stream_buffer (DEPTH=8 and DEPTH=1024).
// Latency: n/a.
// Backpressure: m_axis_tready driven directly by the stimulus.
module tb_fractal_stream_buffer;

  localparam int DW = 24;

  logic aclk   = 1'b0;
  logic areset = 1'b1;

  always #5 aclk = ~aclk;

  // Small instance, DEPTH=8
  logic [DW-1:0] s_data   = '0;
  logic          s_sof    = 1'b0;
  logic          s_eol    = 1'b0;
  logic          s_vld    = 1'b0;
  logic          s_tready = 1'b0;
  logic          s_clr    = 1'b0;
  logic          s_tvalid;
  logic [DW-1:0] s_tdata;
  logic [2:0]    s_tstrb;
  logic          s_tuser;
  logic          s_tlast;
  logic          s_sticky;
  logic [15:0]   s_cnt;
  logic [3:0]    s_level;

  // Large instance, DEPTH=1024
  logic [DW-1:0] b_data   = '0;
  logic          b_sof    = 1'b0;
  logic          b_eol    = 1'b0;
  logic          b_vld    = 1'b0;
  logic          b_tready = 1'b1;
  logic          b_clr    = 1'b0;
  logic          b_tvalid;
  logic [DW-1:0] b_tdata;
  logic [2:0]    b_tstrb;
  logic          b_tuser;
  logic          b_tlast;
  logic          b_sticky;
  logic [15:0]   b_cnt;
  logic [10:0]   b_level;

  fractal_stream_buffer #(.DATA_WIDTH(DW), .DEPTH(8)) u_dut_small (
    .aclk            (aclk),
    .areset          (areset),
    .s_data          (s_data),
    .s_frame_start   (s_sof),
    .s_line_end      (s_eol),
    .s_valid         (s_vld),
    .m_axis_tvalid   (s_tvalid),
    .m_axis_tdata    (s_tdata),
    .m_axis_tstrb    (s_tstrb),
    .m_axis_tuser    (s_tuser),
    .m_axis_tlast    (s_tlast),
    .m_axis_tready   (s_tready),
    .clr_status      (s_clr),
    .overflow_sticky (s_sticky),
    .overflow_count  (s_cnt),
    .level           (s_level)
  );

  fractal_stream_buffer #(.DATA_WIDTH(DW), .DEPTH(1024)) u_dut_big (
    .aclk            (aclk),
    .areset          (areset),
    .s_data          (b_data),
    .s_frame_start   (b_sof),
    .s_line_end      (b_eol),
    .s_valid         (b_vld),
    .m_axis_tvalid   (b_tvalid),
    .m_axis_tdata    (b_tdata),
    .m_axis_tstrb    (b_tstrb),
    .m_axis_tuser    (b_tuser),
    .m_axis_tlast    (b_tlast),
    .m_axis_tready   (b_tready),
    .clr_status      (b_clr),
    .overflow_sticky (b_sticky),
    .overflow_count  (b_cnt),
    .level           (b_level)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // Small-instance capture of accepted beats {tuser, tlast, tdata} and their cycle.
  logic [25:0] cap_q[$];
  int          cap_cyc[$];

  always @(negedge aclk) begin
    if (!areset && s_tvalid && s_tready) begin
      cap_q.push_back({s_tuser, s_tlast, s_tdata});
      cap_cyc.push_back(cyc);
    end
  end

  function automatic logic [31:0] cap_at(input int i);
    if (i < cap_q.size()) return {6'd0, cap_q[i]};
    return 32'hFFFF_FFFF;
  endfunction

  function automatic int cyc_at(input int i);
    if (i < cap_cyc.size()) return cap_cyc[i];
    return -1000;
  endfunction

  // Large-instance scoreboard and stall-stability monitor.
  logic [25:0] exp_q[$];
  logic        big_on       = 1'b0;
  logic        b_prev_stall = 1'b0;
  logic [25:0] b_prev_beat  = '0;

  always @(negedge aclk) begin
    if (big_on) begin
      if (b_prev_stall)
        chk("big_hold", {5'd0, b_tvalid, b_tuser, b_tlast, b_tdata}, {5'd0, 1'b1, b_prev_beat});
      if (b_tvalid && b_tready) begin
        if (exp_q.size() == 0)
          chk("big_unexpected", {6'd0, b_tuser, b_tlast, b_tdata}, 32'hFFFF_FFFF);
        else
          chk("big_beat", {6'd0, b_tuser, b_tlast, b_tdata}, {6'd0, exp_q.pop_front()});
      end
      b_prev_stall <= b_tvalid && !b_tready;
      b_prev_beat  <= {b_tuser, b_tlast, b_tdata};
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic beat(input logic sof, input logic eol, input logic [DW-1:0] d);
    s_vld  = 1'b1;
    s_sof  = sof;
    s_eol  = eol;
    s_data = d;
    tick();
    s_vld  = 1'b0;
    s_sof  = 1'b0;
    s_eol  = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    s_tready = 1'b1;
    while ((s_tvalid || s_level != 0) && k < 64) begin
      tick();
      k++;
    end
    chk(tag, {27'd0, s_tvalid, s_level}, 32'd0);
  endtask

  task automatic do_reset();
    areset = 1'b1;
    tick();
    tick();
    areset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int idx;

    // Reset state
    do_reset();
    chk("rst_tvalid", s_tvalid, 0);
    chk("rst_level", s_level, 0);
    chk("rst_tdata", s_tdata, 0);
    chk("rst_tstrb", s_tstrb, 3'b111);
    chk("rst_cnt", s_cnt, 0);
    chk("rst_sticky", s_sticky, 0);

    // T1: beats before the first frame start are discarded; 2-cycle latency
    s_tready = 1'b1;
    cap_q.delete(); cap_cyc.delete();
    for (int i = 0; i < 5; i++) beat(1'b0, 1'b0, 24'h000100 + 24'(i));
    c0 = cyc;
    for (int i = 0; i < 4; i++) beat(i == 0, i == 3, 24'hA00001 + 24'(i));
    repeat (4) tick();
    chk("t1_count", cap_q.size(), 4);
    chk("t1_b0", cap_at(0), {6'd0, 1'b1, 1'b0, 24'hA00001});
    chk("t1_b1", cap_at(1), {6'd0, 1'b0, 1'b0, 24'hA00002});
    chk("t1_b2", cap_at(2), {6'd0, 1'b0, 1'b0, 24'hA00003});
    chk("t1_b3", cap_at(3), {6'd0, 1'b0, 1'b1, 24'hA00004});
    chk("t1_latency", cyc_at(0) - c0, 2);
    chk("t1_back_to_back", cyc_at(3) - cyc_at(0), 3);
    chk("t1_cnt", s_cnt, 0);

    // T2: 20-beat frame, tready low. Output register holds b0 and storage b1..b8,
    // so b9 is the first overflow.
    s_tready = 1'b0;
    cap_q.delete(); cap_cyc.delete();
    for (int i = 0; i < 20; i++) beat(i == 0, (i % 5) == 4, 24'hB00000 + 24'(i));
    chk("t2_level", s_level, 8);
    chk("t2_cnt", s_cnt, 1);
    chk("t2_sticky", s_sticky, 1);
    chk("t2_head", {s_tvalid, s_tuser, s_tdata}, {6'd0, 1'b1, 1'b1, 24'hB00000});

    // T3: frame start while in DROP and full is dropped without a second count
    beat(1'b1, 1'b0, 24'hC00000);
    chk("t3_cnt", s_cnt, 1);
    chk("t3_level", s_level, 8);
    drain("t3_drain");
    chk("t3_drained", cap_q.size(), 9);
    for (int i = 0; i < 9; i++)
      chk("t3_beat", cap_at(i), {6'd0, i == 0, (i % 5) == 4, 24'hB00000 + 24'(i)});
    cap_q.delete(); cap_cyc.delete();
    for (int i = 0; i < 4; i++) beat(i == 0, i == 3, 24'hD00000 + 24'(i));
    repeat (4) tick();
    chk("t3_new_count", cap_q.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("t3_new_beat", cap_at(i), {6'd0, i == 0, i == 3, 24'hD00000 + 24'(i)});
    chk("t3_cnt_after", s_cnt, 1);

    // T4: clear coincident with an overflow, then a lone clear
    s_tready = 1'b0;
    cap_q.delete(); cap_cyc.delete();
    for (int i = 0; i < 9; i++) beat(i == 0, 1'b0, 24'hE00000 + 24'(i));
    chk("t4_level", s_level, 8);
    s_clr = 1'b1;
    beat(1'b0, 1'b0, 24'hE00009);
    s_clr = 1'b0;
    chk("t4_cnt_ovf_clr", s_cnt, 1);
    chk("t4_sticky_ovf_clr", s_sticky, 1);
    s_clr = 1'b1;
    tick();
    s_clr = 1'b0;
    chk("t4_cnt_clr", s_cnt, 0);
    chk("t4_sticky_clr", s_sticky, 0);
    drain("t4_drain");
    chk("t4_drained", cap_q.size(), 9);

    // T5: reset mid-frame with 6 entries in storage
    s_tready = 1'b0;
    for (int i = 0; i < 10; i++) beat(i == 0, 1'b0, 24'hF10000 + 24'(i));
    drain("t5_drain");
    s_tready = 1'b0;
    for (int i = 0; i < 7; i++) beat(i == 0, 1'b0, 24'hF20000 + 24'(i));
    chk("t5_level_pre", s_level, 6);
    chk("t5_cnt_pre", s_cnt, 1);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    chk("t5_tvalid", s_tvalid, 0);
    chk("t5_level", s_level, 0);
    chk("t5_outs", {s_tuser, s_tlast, s_tdata}, 0);
    chk("t5_tstrb", s_tstrb, 3'b111);
    chk("t5_cnt", s_cnt, 0);
    chk("t5_sticky", s_sticky, 0);
    s_tready = 1'b1;
    cap_q.delete(); cap_cyc.delete();
    beat(1'b0, 1'b1, 24'hF30000);
    repeat (4) tick();
    chk("t5_nosof_dropped", cap_q.size(), 0);
    chk("t5_level_post", s_level, 0);
    beat(1'b1, 1'b0, 24'hF40000);
    repeat (3) tick();
    chk("t5_sof_count", cap_q.size(), 1);
    chk("t5_sof_beat", cap_at(0), {6'd0, 1'b1, 1'b0, 24'hF40000});

    // T6: 1920x4 frame at 2 beats per 5 cycles, random tready, DEPTH=1024
    big_on = 1'b1;
    idx = 0;
    for (int c = 0; c < 40000 && (idx < 7680 || exp_q.size() != 0); c++) begin
      b_tready = 1'($urandom_range(0, 1));
      if (idx < 7680 && (c % 5) < 2) begin
        b_vld  = 1'b1;
        b_sof  = (idx == 0);
        b_eol  = ((idx % 1920) == 1919);
        b_data = {8'h5A, idx[15:0]};
        exp_q.push_back({b_sof, b_eol, b_data});
        idx++;
      end else begin
        b_vld = 1'b0;
        b_sof = 1'b0;
        b_eol = 1'b0;
      end
      tick();
    end
    b_vld = 1'b0;
    b_sof = 1'b0;
    b_eol = 1'b0;
    big_on = 1'b0;
    chk("big_all_sent", idx, 7680);
    chk("big_drained", exp_q.size(), 0);
    chk("big_cnt", b_cnt, 0);
    chk("big_sticky", b_sticky, 0);
    chk("big_level", b_level, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
